// File: rtl/matrix_pkg.sv
// matrix_packer shared types, index sizing and element offset helper.
// Optional ping-pong buffering: MATRIX_PACKER_DOUBLE_BUF_EN.
package matrix_pkg;

  typedef logic [0:0] state_t;

  localparam state_t S_FILL = 1'b0;
  localparam state_t S_HOLD = 1'b1;

  // Index width for the default 16x16 matrix.
  localparam int IDX_W_DEFAULT = 8;

  function automatic int idx_bits(
    input int m,
    input int n
  );
    return (m * n > 1) ? $clog2(m * n) : 1;
  endfunction

  function automatic int elem_off(
    input int i,
    input int j,
    input int n,
    input int dw
  );
    return (n * i + j) * dw;
  endfunction

endpackage

// File: rtl/matrix_packer_if.sv
// matrix_packer stream-in / matrix-out handshake bundle.
// Shared by both buffering builds (MATRIX_PACKER_DOUBLE_BUF_EN).
interface matrix_packer_if #(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int DATA_WIDTH = 8
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [M*N*DATA_WIDTH-1:0] out_mat;
  logic                      err;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_mat,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_mat,
    output err
  );

endinterface

// File: rtl/matrix_bank.sv
// One M*N element store with per-element write enable.
// Instanced once, or twice with MATRIX_PACKER_DOUBLE_BUF_EN.
module matrix_bank
  import matrix_pkg::*;
#(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = idx_bits(M, N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_we,
  input  logic [IDX_W-1:0]          i_idx,
  input  logic [DATA_WIDTH-1:0]     i_data,
  output logic [M*N*DATA_WIDTH-1:0] o_mat
);

  for (genvar e = 0; e < M * N; e++) begin : g_elem
    localparam int OFF = elem_off(e / N, e % N, N, DATA_WIDTH);

    logic                  w_we;
    logic [DATA_WIDTH-1:0] r_elem;

    assign w_we = i_we && (i_idx == IDX_W'(e));

    // Capture the element when its slot is addressed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_elem <= '0;
      end else if (w_we) begin
        r_elem <= i_data;
      end
    end

    assign o_mat[OFF +: DATA_WIDTH] = r_elem;
  end

endmodule

// File: rtl/matrix_packer.sv
// Packs a row-major element stream into one M*N matrix word.
// Define MATRIX_PACKER_DOUBLE_BUF_EN for ping-pong buffering.
module matrix_packer
  import matrix_pkg::*;
#(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  matrix_packer_if.slave bus
);

  localparam int IDX_W = idx_bits(M, N);
  localparam int LAST  = M * N - 1;

  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic             w_acc;
  logic             w_at_last;
  logic             w_done;

  assign w_acc     = bus.in_valid && bus.in_ready;
  assign w_at_last = (r_idx == IDX_W'(LAST));
  assign w_done    = w_acc && w_at_last;
  assign bus.err   = r_err;

  // Write index walks 0..M*N-1 and wraps, framing errors ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_acc) begin
      r_idx <= w_at_last ? '0 : r_idx + 1'b1;
    end
  end

  // Sticky flag for in_last disagreeing with the index position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_acc && (bus.in_last != w_at_last)) begin
      r_err <= 1'b1;
    end
  end

`ifdef MATRIX_PACKER_DOUBLE_BUF_EN

  logic [1:0]                  r_full;
  logic                        r_wsel;
  logic                        r_rsel;
  logic                        w_drain;
  logic [M*N*DATA_WIDTH-1:0]   w_mat0;
  logic [M*N*DATA_WIDTH-1:0]   w_mat1;

  assign bus.in_ready  = ~(r_full[0] & r_full[1]);
  assign bus.out_valid = r_full[r_rsel];
  assign bus.out_mat   = r_rsel ? w_mat1 : w_mat0;
  assign w_drain       = bus.out_valid && bus.out_ready;

  // Write bank is never the full read bank, so both updates can land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 2'b00;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
    end else begin
      if (w_done) begin
        r_full[r_wsel] <= 1'b1;
        r_wsel         <= ~r_wsel;
      end
      if (w_drain) begin
        r_full[r_rsel] <= 1'b0;
        r_rsel         <= ~r_rsel;
      end
    end
  end

  matrix_bank #(
    .M          (M),
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_acc && !r_wsel),
    .i_idx  (r_idx),
    .i_data (bus.in_data),
    .o_mat  (w_mat0)
  );

  matrix_bank #(
    .M          (M),
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_acc && r_wsel),
    .i_idx  (r_idx),
    .i_data (bus.in_data),
    .o_mat  (w_mat1)
  );

`else

  state_t r_state;

  assign bus.in_ready  = (r_state == S_FILL);
  assign bus.out_valid = (r_state == S_HOLD);

  // Fill until the last slot lands, then hold until downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      case (r_state)
        S_FILL:  if (w_done) r_state <= S_HOLD;
        S_HOLD:  if (bus.out_ready) r_state <= S_FILL;
        default: r_state <= S_FILL;
      endcase
    end
  end

  matrix_bank #(
    .M          (M),
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_acc),
    .i_idx  (r_idx),
    .i_data (bus.in_data),
    .o_mat  (bus.out_mat)
  );

`endif

endmodule
